dmem_arbiter: RTL and testbench

//  Two-requester arbiter/sequencer for the single-port data memory (DMem). Shares the one
//  req/write port between the core load-store unit (LSU, port A) and the debug/program

---
 rtl/dmem_arbiter_pkg.sv | 33 +++
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter_align_chk.sv | 20 ++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the data-memory arbiter slice.
package dmem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_WIDTH = 16;
    localparam int unsigned MEM_WORD_WIDTH = 32;

    // Access size as seen by DMem; 2'b11 is treated as a word access.
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10
    } dmem_size_e;

    typedef struct packed {
        logic                      we;
        logic [1:0]                size;
        logic [MEM_ADDR_WIDTH-1:0] addr;
        logic [MEM_WORD_WIDTH-1:0] wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LSU,
        ST_DBG,
        ST_LOCKED
    } dmem_arb_st_e;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_DBG = 1'b1
    } dmem_req_id_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side request/response bundle. master = requester, slave = arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_WIDTH,
    parameter int unsigned WORD_W = MEM_WORD_WIDTH
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [WORD_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, size, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, size, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_align_chk.sv
// Combinational alignment check: flags halves on odd addresses and words off a 4-byte boundary.
module dmem_align_chk
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       misaligned_o
);

    // Byte accesses are always aligned; 2'b11 falls into the word case.
    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SZ_BYTE: misaligned_o = 1'b0;
            SZ_HALF: misaligned_o = addr_lo_i[0];
            default: misaligned_o = (addr_lo_i != 2'b00);
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMem arbiter: LSU (port A) and debug loader (port B) share one DMem port.
// Grants are combinational, responses return one cycle later to the owning port.
// Optional DMEM_ARB_PERF_CNT_EN adds saturating wait/error counters and perf_* outputs.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_WIDTH,
    parameter int unsigned WORD_W   = MEM_WORD_WIDTH,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     lsu,
    dmem_arbiter_if.slave     dbg,
    input  logic              dbg_lock,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_err
`ifdef DMEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_lsu_wait,
    output logic [31:0]       perf_dbg_wait,
    output logic [31:0]       perf_err
`endif
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    dmem_arb_st_e      st_q, st_d;
    dmem_req_id_e      last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

    logic              gnt_lsu, gnt_dbg, lock_hold;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [WORD_W-1:0] sel_wdata;
    logic              misal;

    logic              rsp_vld_q, rsp_misal_q, rsp_we_q;
    dmem_req_id_e      rsp_owner_q;

    // DBG keeps the bus only while it is mid-burst and still asking for the lock.
    assign lock_hold = (st_q == ST_LOCKED) && dbg.req && dbg_lock;

    // Grant selection: lock first, then round-robin on ties; nothing is granted in reset.
    always_comb begin
        gnt_lsu = 1'b0;
        gnt_dbg = 1'b0;
        if (rst_n) begin
            if (lock_hold) begin
                gnt_dbg = 1'b1;
            end else if (lsu.req && dbg.req) begin
                if (last_gnt_q == REQ_DBG) gnt_lsu = 1'b1;
                else                       gnt_dbg = 1'b1;
            end else if (lsu.req) begin
                gnt_lsu = 1'b1;
            end else if (dbg.req) begin
                gnt_dbg = 1'b1;
            end
        end
    end

    // Next state: track last owner and count consecutive locked DBG grants.
    always_comb begin
        st_d       = ST_IDLE;
        last_gnt_d = last_gnt_q;
        lock_cnt_d = '0;
        if (gnt_lsu) begin
            st_d       = ST_LSU;
            last_gnt_d = REQ_LSU;
        end else if (gnt_dbg) begin
            st_d       = ST_DBG;
            last_gnt_d = REQ_DBG;
            if (dbg_lock) begin
                if (st_q == ST_LOCKED) begin
                    // The LOCK_MAX-th grant ends the burst so a waiting LSU wins next cycle.
                    if (lock_cnt_q != CNT_W'(LOCK_MAX - 1)) begin
                        st_d       = ST_LOCKED;
                        lock_cnt_d = lock_cnt_q + 1'b1;
                    end
                end else if (LOCK_MAX > 1) begin
                    st_d       = ST_LOCKED;
                    lock_cnt_d = CNT_W'(1);
                end
            end
        end
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            last_gnt_q <= REQ_DBG;
            lock_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            last_gnt_q <= last_gnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Route the granted requester onto the DMem port.
    always_comb begin
        sel_we    = lsu.we;
        sel_size  = lsu.size;
        sel_addr  = lsu.addr;
        sel_wdata = lsu.wdata;
        if (gnt_dbg) begin
            sel_we    = dbg.we;
            sel_size  = dbg.size;
            sel_addr  = dbg.addr;
            sel_wdata = dbg.wdata;
        end
    end

    dmem_align_chk u_align_chk (
        .size_i      (sel_size),
        .addr_lo_i   (sel_addr[1:0]),
        .misaligned_o(misal)
    );

    // Misaligned accesses are granted but never reach DMem.
    assign mem_req   = (gnt_lsu || gnt_dbg) && !misal;
    assign mem_we    = mem_req && sel_we;
    assign mem_size  = sel_size;
    assign mem_addr  = sel_addr;
    assign mem_wdata = sel_wdata;

    assign lsu.gnt = gnt_lsu;
    assign dbg.gnt = gnt_dbg;

    // Remember who owns the DMem response due next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q   <= 1'b0;
            rsp_owner_q <= REQ_LSU;
            rsp_misal_q <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_vld_q <= gnt_lsu || gnt_dbg;
            if (gnt_lsu || gnt_dbg) begin
                rsp_owner_q <= gnt_dbg ? REQ_DBG : REQ_LSU;
                rsp_misal_q <= misal;
                rsp_we_q    <= sel_we;
            end
        end
    end

    // Steer the response; rdata only for aligned loads since DMem was idle otherwise.
    always_comb begin
        lsu.rvalid = rsp_vld_q && (rsp_owner_q == REQ_LSU);
        dbg.rvalid = rsp_vld_q && (rsp_owner_q == REQ_DBG);
        lsu.err    = lsu.rvalid && (mem_err || rsp_misal_q);
        dbg.err    = dbg.rvalid && (mem_err || rsp_misal_q);
        lsu.rdata  = '0;
        dbg.rdata  = '0;
        if (!rsp_we_q && !rsp_misal_q) begin
            if (lsu.rvalid) lsu.rdata = mem_rdata;
            if (dbg.rvalid) dbg.rdata = mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] lsu_wait_cnt_q, dbg_wait_cnt_q, err_cnt_q;

    // Saturating wait-cycle and error-response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lsu_wait_cnt_q <= '0;
            dbg_wait_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            if (lsu.req && !gnt_lsu && (lsu_wait_cnt_q != '1)) lsu_wait_cnt_q <= lsu_wait_cnt_q + 32'd1;
            if (dbg.req && !gnt_dbg && (dbg_wait_cnt_q != '1)) dbg_wait_cnt_q <= dbg_wait_cnt_q + 32'd1;
            if ((lsu.err || dbg.err) && (err_cnt_q != '1))     err_cnt_q      <= err_cnt_q + 32'd1;
        end
    end

    assign perf_lsu_wait = lsu_wait_cnt_q;
    assign perf_dbg_wait = dbg_wait_cnt_q;
    assign perf_err      = err_cnt_q;
`endif

    // A requester must hold req until granted; the two grants are mutually exclusive.
    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (lsu.req && !lsu.gnt) |=> lsu.req);
    a_dbg_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (dbg.req && !dbg.gnt) |=> dbg.req);
    a_one_gnt: assert property (@(posedge clk) !(lsu.gnt && dbg.gnt));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a rule-level model and a small DMem stand-in.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned LMAX      = 4;
    localparam int unsigned MEM_WORDS = 1024;
    localparam logic [15:0] MEM_BASE  = 16'h4000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dbg_lock;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_err;
`ifdef DMEM_ARB_PERF_CNT_EN
    logic [31:0] perf_lsu_wait, perf_dbg_wait, perf_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    dmem_arbiter_if #(.ADDR_W(16), .WORD_W(32)) lsu_if ();
    dmem_arbiter_if #(.ADDR_W(16), .WORD_W(32)) dbg_if ();

    dmem_arbiter #(
        .ADDR_W  (16),
        .WORD_W  (32),
        .LOCK_MAX(LMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu          (lsu_if),
        .dbg          (dbg_if),
        .dbg_lock     (dbg_lock),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_err      (mem_err)
`ifdef DMEM_ARB_PERF_CNT_EN
        ,
        .perf_lsu_wait(perf_lsu_wait),
        .perf_dbg_wait(perf_dbg_wait),
        .perf_err     (perf_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic is_misal(logic [1:0] sz, logic [15:0] a);
        if (sz == 2'b01) return 1'b0;
        if (sz == 2'b10) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic in_range(logic [15:0] a);
        return (a >= MEM_BASE) && (a < MEM_BASE + 16'(MEM_WORDS * 4));
    endfunction

    function automatic int widx(logic [15:0] a);
        return int'((a - MEM_BASE) >> 2);
    endfunction

    function automatic logic [31:0] rd_ext(logic [31:0] w, logic [15:0] a, logic [1:0] sz);
        if (sz == 2'b01) return (w >> (8 * a[1:0])) & 32'hFF;
        if (sz == 2'b10) return (w >> (16 * a[1])) & 32'hFFFF;
        return w;
    endfunction

    function automatic logic [31:0] wr_merge(logic [31:0] w, logic [15:0] a, logic [1:0] sz,
                                             logic [31:0] d);
        logic [31:0] m;
        logic [31:0] v;
        m = 32'hFFFF_FFFF;
        v = d;
        if (sz == 2'b01) begin
            m = 32'hFF << (8 * a[1:0]);
            v = d << (8 * a[1:0]);
        end else if (sz == 2'b10) begin
            m = 32'hFFFF << (16 * a[1]);
            v = d << (16 * a[1]);
        end
        return (w & ~m) | (v & m);
    endfunction

    // DMem stand-in: registered 1-cycle read, addr_err outside the mapped window.
    initial begin : dmem_stub
        mem_rdata = '0;
        mem_err   = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) dmem[i] = '0;
        dmem[0] = 32'h1234_5678;
        dmem[1] = 32'hCAFE_F00D;
        dmem[2] = 32'h0BAD_BEEF;
        forever begin
            @(posedge clk);
            if (mem_req === 1'b1) begin
                if (in_range(mem_addr)) begin
                    mem_err = 1'b0;
                    if (mem_we) begin
                        dmem[widx(mem_addr)] = wr_merge(dmem[widx(mem_addr)], mem_addr, mem_size,
                                                        mem_wdata);
                        mem_rdata = '0;
                    end else begin
                        mem_rdata = rd_ext(dmem[widx(mem_addr)], mem_addr, mem_size);
                    end
                end else begin
                    mem_err   = 1'b1;
                    mem_rdata = '0;
                end
            end else begin
                mem_err   = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Reference model and per-cycle compare, sampled on the falling edge.
    initial begin : model
        logic        m_last_dbg, m_vld, m_own_dbg, m_err;
        logic [31:0] m_rdata;
        int          m_run;
        logic        gl, gd, mis, we;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] wd;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
        ref_mem[0] = 32'h1234_5678;
        ref_mem[1] = 32'hCAFE_F00D;
        ref_mem[2] = 32'h0BAD_BEEF;
        m_last_dbg = 1'b1;
        m_vld      = 1'b0;
        m_own_dbg  = 1'b0;
        m_err      = 1'b0;
        m_rdata    = '0;
        m_run      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_last_dbg = 1'b1;
                m_vld      = 1'b0;
                m_run      = 0;
                chk("rst_lsu_gnt", 32'(lsu_if.gnt), 32'd0);
                chk("rst_dbg_gnt", 32'(dbg_if.gnt), 32'd0);
                chk("rst_mem_req", 32'(mem_req), 32'd0);
                chk("rst_rvalid", 32'({lsu_if.rvalid, dbg_if.rvalid}), 32'd0);
            end else begin
                chk("lsu_rvalid", 32'(lsu_if.rvalid), 32'(m_vld && !m_own_dbg));
                chk("dbg_rvalid", 32'(dbg_if.rvalid), 32'(m_vld && m_own_dbg));
                if (m_vld && m_own_dbg) begin
                    chk("dbg_err", 32'(dbg_if.err), 32'(m_err));
                    chk("dbg_rdata", dbg_if.rdata, m_rdata);
                end else if (m_vld) begin
                    chk("lsu_err", 32'(lsu_if.err), 32'(m_err));
                    chk("lsu_rdata", lsu_if.rdata, m_rdata);
                end
                gl = 1'b0;
                gd = 1'b0;
                if (m_run > 0 && dbg_if.req && dbg_lock) gd = 1'b1;
                else if (lsu_if.req && dbg_if.req) begin
                    if (m_last_dbg) gl = 1'b1;
                    else            gd = 1'b1;
                end else if (lsu_if.req) gl = 1'b1;
                else if (dbg_if.req) gd = 1'b1;
                chk("lsu_gnt", 32'(lsu_if.gnt), 32'(gl));
                chk("dbg_gnt", 32'(dbg_if.gnt), 32'(gd));
                m_vld = 1'b0;
                if (gl || gd) begin
                    we  = gd ? dbg_if.we    : lsu_if.we;
                    sz  = gd ? dbg_if.size  : lsu_if.size;
                    a   = gd ? dbg_if.addr  : lsu_if.addr;
                    wd  = gd ? dbg_if.wdata : lsu_if.wdata;
                    mis = is_misal(sz, a);
                    chk("mem_req", 32'(mem_req), 32'(!mis));
                    if (!mis) begin
                        chk("mem_addr", 32'(mem_addr), 32'(a));
                        chk("mem_we", 32'(mem_we), 32'(we));
                        chk("mem_size", 32'(mem_size), 32'(sz));
                        if (we) chk("mem_wdata", mem_wdata, wd);
                    end
                    m_err   = mis || !in_range(a);
                    m_rdata = '0;
                    if (!m_err && !we) m_rdata = rd_ext(ref_mem[widx(a)], a, sz);
                    if (!m_err && we) ref_mem[widx(a)] = wr_merge(ref_mem[widx(a)], a, sz, wd);
                    m_vld      = 1'b1;
                    m_own_dbg  = gd;
                    m_last_dbg = gd;
                    if (gd && dbg_lock) m_run = (m_run + 1 == int'(LMAX)) ? 0 : m_run + 1;
                    else                m_run = 0;
                end else begin
                    chk("mem_req_idle", 32'(mem_req), 32'd0);
                    m_run = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lsu(logic r, logic w, logic [1:0] s, logic [15:0] a, logic [31:0] d);
        lsu_if.req = r; lsu_if.we = w; lsu_if.size = s; lsu_if.addr = a; lsu_if.wdata = d;
    endtask

    task automatic set_dbg(logic r, logic w, logic [1:0] s, logic [15:0] a, logic [31:0] d);
        dbg_if.req = r; dbg_if.we = w; dbg_if.size = s; dbg_if.addr = a; dbg_if.wdata = d;
    endtask

    task automatic rnd_fields(output logic w, output logic [1:0] s, output logic [15:0] a,
                              output logic [31:0] d);
        logic [15:0] base;
        base = ($urandom_range(0, 9) == 0) ? 16'h0000 : MEM_BASE;
        a    = base + 16'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
        s = 2'($urandom_range(0, 3));
        w = 1'($urandom_range(0, 1));
        d = $urandom;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : stim
        logic gl, gd;
        rst_n    = 1'b0;
        dbg_lock = 1'b0;
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4000, '0);
        set_dbg(1'b0, 1'b0, SZ_WORD, '0, '0);
        @(negedge clk);
        chk("reset_no_gnt", 32'(lsu_if.gnt), 32'd0);
        chk("reset_no_memreq", 32'(mem_req), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // 1: lone LSU word load
        @(negedge clk);
        chk("t1_lsu_gnt", 32'(lsu_if.gnt), 32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h4000);
        step();
        set_lsu(1'b0, 1'b0, SZ_WORD, '0, '0);
        set_dbg(1'b1, 1'b0, SZ_WORD, 16'h0010, '0);
        @(negedge clk);
        chk("t1_lsu_rvalid", 32'(lsu_if.rvalid), 32'd1);
        chk("t1_lsu_rdata", lsu_if.rdata, 32'h1234_5678);
        chk("t5_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
        // 5: DBG load below DMem base
        step();
        set_dbg(1'b0, 1'b0, SZ_WORD, '0, '0);
        @(negedge clk);
        chk("t5_dbg_rvalid", 32'(dbg_if.rvalid), 32'd1);
        chk("t5_dbg_err", 32'(dbg_if.err), 32'd1);

        // 2: continuous tie alternates starting with LSU
        step();
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4004, '0);
        set_dbg(1'b1, 1'b0, SZ_WORD, 16'h4008, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", i), 32'({lsu_if.gnt, dbg_if.gnt}),
                (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i < 5) step();
        end
        step();
        set_dbg(1'b0, 1'b0, SZ_WORD, '0, '0);
        @(negedge clk);
        chk("t2_tail_lsu_gnt", 32'(lsu_if.gnt), 32'd1);
        chk("t2_dbg_rdata", dbg_if.rdata, 32'h0BAD_BEEF);

        // 3: locked DBG burst, LSU waits LOCK_MAX grants
        step();
        dbg_lock = 1'b1;
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4004, '0);
        set_dbg(1'b1, 1'b0, SZ_WORD, 16'h4008, '0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_gnt%0d", i), 32'({lsu_if.gnt, dbg_if.gnt}),
                (i < 4) ? 32'd1 : 32'd2);
            if (i < 4) step();
        end
        step();
        set_lsu(1'b0, 1'b0, SZ_WORD, '0, '0);
        dbg_lock = 1'b0;
        @(negedge clk);
        chk("t3_tail_dbg_gnt", 32'(dbg_if.gnt), 32'd1);
        chk("t3_lsu_rdata", lsu_if.rdata, 32'hCAFE_F00D);

        // 4: misaligned half store must not touch memory
        step();
        set_dbg(1'b0, 1'b0, SZ_WORD, '0, '0);
        set_lsu(1'b1, 1'b1, SZ_HALF, 16'h4001, 32'h0000_BEEF);
        @(negedge clk);
        chk("t4_gnt", 32'(lsu_if.gnt), 32'd1);
        chk("t4_mem_req", 32'(mem_req), 32'd0);
        step();
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4000, '0);
        @(negedge clk);
        chk("t4_rvalid", 32'(lsu_if.rvalid), 32'd1);
        chk("t4_err", 32'(lsu_if.err), 32'd1);
        step();
        set_lsu(1'b0, 1'b0, SZ_WORD, '0, '0);
        @(negedge clk);
        chk("t4_mem_unchanged", lsu_if.rdata, 32'h1234_5678);

        // 6: reset right after a grant drops the response; first tie goes to LSU
        step();
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4000, '0);
        @(negedge clk);
        chk("t6_gnt", 32'(lsu_if.gnt), 32'd1);
        step();
        set_lsu(1'b0, 1'b0, SZ_WORD, '0, '0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_rvalid", 32'(lsu_if.rvalid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        set_lsu(1'b1, 1'b0, SZ_WORD, 16'h4004, '0);
        set_dbg(1'b1, 1'b0, SZ_WORD, 16'h4008, '0);
        @(negedge clk);
        chk("t6_no_rvalid", 32'({lsu_if.rvalid, dbg_if.rvalid}), 32'd0);
        chk("t6_tie_lsu", 32'({lsu_if.gnt, dbg_if.gnt}), 32'd2);
        step();
        set_lsu(1'b0, 1'b0, SZ_WORD, '0, '0);
        @(negedge clk);
        chk("t6_dbg_next", 32'(dbg_if.gnt), 32'd1);
        step();
        set_dbg(1'b0, 1'b0, SZ_WORD, '0, '0);

        // Randomized traffic; a pending request is held until granted.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gl = lsu_if.gnt;
            gd = dbg_if.gnt;
            step();
            if (!lsu_if.req || gl) begin
                lsu_if.req = ($urandom_range(0, 99) < 55);
                if (lsu_if.req) rnd_fields(lsu_if.we, lsu_if.size, lsu_if.addr, lsu_if.wdata);
            end
            if (!dbg_if.req || gd) begin
                dbg_if.req = ($urandom_range(0, 99) < 55);
                if (dbg_if.req) rnd_fields(dbg_if.we, dbg_if.size, dbg_if.addr, dbg_if.wdata);
            end
            if ($urandom_range(0, 15) == 0) dbg_lock = !dbg_lock;
        end
        for (int c = 0; c < 100 && (lsu_if.req || dbg_if.req); c++) begin
            @(negedge clk);
            gl = lsu_if.gnt;
            gd = dbg_if.gnt;
            step();
            if (gl) lsu_if.req = 1'b0;
            if (gd) dbg_if.req = 1'b0;
        end
        chk("drain_all_granted", 32'({lsu_if.req, dbg_if.req}), 32'd0);
        step();
        step();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
